// File: rtl/swervolf_axi_mem.sv
// swervolf_axi_mem: parametrised AXI4 slave memory used as boot ROM or scratch RAM.
// Independent read and write channel FSMs with FIXED/INCR/WRAP burst addressing.
// Optional feature macro SWERVOLF_AXI_MEM_WP_EN: write-protected (ROM) build in which
// every W beat is accepted and discarded and the write response is SLVERR.
module swervolf_axi_mem #(
   parameter int ID_WIDTH   = 6,
   parameter int DATA_WIDTH = 64,
   parameter int MEM_SIZE   = 32'h1000,
   parameter     INIT_FILE  = ""
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [ID_WIDTH-1:0]     i_awid,
   input  logic [31:0]             i_awaddr,
   input  logic [7:0]              i_awlen,
   input  logic [2:0]              i_awsize,
   input  logic [1:0]              i_awburst,
   input  logic                    i_awvalid,
   output logic                    o_awready,
   input  logic [DATA_WIDTH-1:0]   i_wdata,
   input  logic [DATA_WIDTH/8-1:0] i_wstrb,
   input  logic                    i_wlast,
   input  logic                    i_wvalid,
   output logic                    o_wready,
   output logic [ID_WIDTH-1:0]     o_bid,
   output logic [1:0]              o_bresp,
   output logic                    o_bvalid,
   input  logic                    i_bready,
   input  logic [ID_WIDTH-1:0]     i_arid,
   input  logic [31:0]             i_araddr,
   input  logic [7:0]              i_arlen,
   input  logic [2:0]              i_arsize,
   input  logic [1:0]              i_arburst,
   input  logic                    i_arvalid,
   output logic                    o_arready,
   output logic [ID_WIDTH-1:0]     o_rid,
   output logic [DATA_WIDTH-1:0]   o_rdata,
   output logic [1:0]              o_rresp,
   output logic                    o_rlast,
   output logic                    o_rvalid,
   input  logic                    i_rready
);

   localparam int BYTES  = DATA_WIDTH / 8;
   localparam int OFF    = $clog2(BYTES);
   localparam int MEM_AW = $clog2(MEM_SIZE);
   localparam int IDX_W  = MEM_AW - OFF;
   localparam int DEPTH  = MEM_SIZE / BYTES;

`ifdef SWERVOLF_AXI_MEM_WP_EN
   localparam logic [1:0] BRESP_CODE = 2'b10;
`else
   localparam logic [1:0] BRESP_CODE = 2'b00;
`endif

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Upper address bits are dropped, so the array aliases modulo MEM_SIZE.
   function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
      word_idx = addr[MEM_AW-1:OFF];
   endfunction

   // Address of the next beat; WRAP with an illegal length and the reserved type fall back to INCR.
   function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [7:0] len,
                                             input logic [2:0] size, input logic [1:0] burst);
      logic [31:0] step;
      logic [31:0] mask;
      logic        wrap_ok;
      step    = 32'd1 << size;
      mask    = (({24'd0, len} + 32'd1) << size) - 32'd1;
      wrap_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
      next_addr = addr + step;
      if (burst == 2'b00)
         next_addr = addr;
      else if ((burst == 2'b10) && wrap_ok)
         next_addr = (addr & ~mask) | ((addr + step) & mask);
   endfunction

   // ---------------- write channel ----------------
   w_state_t    w_state, w_state_nxt;
   logic [31:0] aw_addr;
   logic [7:0]  aw_len;
   logic [2:0]  aw_size;
   logic [1:0]  aw_burst;
   logic        aw_hs, w_hs;

   assign aw_hs = i_awvalid && o_awready;
   assign w_hs  = i_wvalid && o_wready;

   // Write FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) w_state <= W_IDLE;
      else        w_state <= w_state_nxt;
   end

   // Write FSM next state; handshake readies depend on state only.
   always_comb begin
      w_state_nxt = w_state;
      o_awready   = 1'b0;
      o_wready    = 1'b0;
      o_bvalid    = 1'b0;
      case (w_state)
         W_IDLE: begin
            o_awready = 1'b1;
            if (i_awvalid) w_state_nxt = W_DATA;
         end
         W_DATA: begin
            o_wready = 1'b1;
            if (i_wvalid && i_wlast) w_state_nxt = W_RESP;
         end
         W_RESP: begin
            o_bvalid = 1'b1;
            if (i_bready) w_state_nxt = W_IDLE;
         end
         default: w_state_nxt = W_IDLE;
      endcase
   end

   // Latch the write request and walk the burst address one beat at a time.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aw_addr  <= '0;
         aw_len   <= '0;
         aw_size  <= '0;
         aw_burst <= '0;
         o_bid    <= '0;
         o_bresp  <= '0;
      end else begin
         if (aw_hs) begin
            aw_addr  <= i_awaddr;
            aw_len   <= i_awlen;
            aw_size  <= i_awsize;
            aw_burst <= i_awburst;
            o_bid    <= i_awid;
         end else if (w_hs) begin
            aw_addr <= next_addr(aw_addr, aw_len, aw_size, aw_burst);
         end
         if (w_hs && i_wlast) o_bresp <= BRESP_CODE;
      end
   end

`ifndef SWERVOLF_AXI_MEM_WP_EN
   // Byte-masked array write, one word per accepted W beat.
   always_ff @(posedge clk) begin
      if (w_hs) begin
         for (int b = 0; b < BYTES; b++)
            if (i_wstrb[b]) mem[word_idx(aw_addr)][8*b +: 8] <= i_wdata[8*b +: 8];
      end
   end
`endif

   // ---------------- read channel ----------------
   r_state_t    r_state, r_state_nxt;
   logic [31:0] ar_addr;
   logic [7:0]  ar_len;
   logic [7:0]  r_cnt;
   logic [2:0]  ar_size;
   logic [1:0]  ar_burst;
   logic        ar_hs, r_hs;

   assign ar_hs   = i_arvalid && o_arready;
   assign r_hs    = i_rready && o_rvalid;
   assign o_rlast = o_rvalid && (r_cnt == 8'd0);
   assign o_rresp = 2'b00;

   // Read FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= R_IDLE;
      else        r_state <= r_state_nxt;
   end

   // Read FSM next state; leave R_DATA once the last beat is taken.
   always_comb begin
      r_state_nxt = r_state;
      o_arready   = 1'b0;
      o_rvalid    = 1'b0;
      case (r_state)
         R_IDLE: begin
            o_arready = 1'b1;
            if (i_arvalid) r_state_nxt = R_DATA;
         end
         R_DATA: begin
            o_rvalid = 1'b1;
            if (i_rready && (r_cnt == 8'd0)) r_state_nxt = R_IDLE;
         end
         default: r_state_nxt = R_IDLE;
      endcase
   end

   // Registered array read: beat 0 on AR accept, beat k+1 on the handshake of beat k.
   // A same-cycle write to the same word is not visible to this read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ar_addr  <= '0;
         ar_len   <= '0;
         ar_size  <= '0;
         ar_burst <= '0;
         r_cnt    <= '0;
         o_rid    <= '0;
         o_rdata  <= '0;
      end else if (ar_hs) begin
         o_rid    <= i_arid;
         o_rdata  <= mem[word_idx(i_araddr)];
         ar_addr  <= next_addr(i_araddr, i_arlen, i_arsize, i_arburst);
         ar_len   <= i_arlen;
         ar_size  <= i_arsize;
         ar_burst <= i_arburst;
         r_cnt    <= i_arlen;
      end else if (r_hs && (r_cnt != 8'd0)) begin
         o_rdata <= mem[word_idx(ar_addr)];
         ar_addr <= next_addr(ar_addr, ar_len, ar_size, ar_burst);
         r_cnt   <= r_cnt - 8'd1;
      end
   end

endmodule

// File: tb/tb_swervolf_axi_mem.sv
// Bench for swervolf_axi_mem (64-bit, 4 KiB): table-driven burst reads, hand-written
// corner sequences and randomized bursts against a word-array reference model.
`timescale 1ns/1ps
module tb_swervolf_axi_mem;
   localparam int IDW   = 6;
   localparam int DW    = 64;
   localparam int MS    = 32'h1000;
   localparam int DEPTH = MS / 8;
`ifdef SWERVOLF_AXI_MEM_WP_EN
   localparam logic [1:0] EXP_BRESP = 2'b10;
`else
   localparam logic [1:0] EXP_BRESP = 2'b00;
`endif

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [IDW-1:0] i_awid = '0, i_arid = '0, o_bid, o_rid;
   logic [31:0]    i_awaddr = '0, i_araddr = '0;
   logic [7:0]     i_awlen = '0, i_arlen = '0;
   logic [2:0]     i_awsize = '0, i_arsize = '0;
   logic [1:0]     i_awburst = '0, i_arburst = '0, o_bresp, o_rresp;
   logic           i_awvalid = 1'b0, i_wvalid = 1'b0, i_wlast = 1'b0, i_bready = 1'b0;
   logic           i_arvalid = 1'b0, i_rready = 1'b0;
   logic           o_awready, o_wready, o_bvalid, o_arready, o_rvalid, o_rlast;
   logic [DW-1:0]  i_wdata = '0, o_rdata;
   logic [7:0]     i_wstrb = '0;

   always #5 clk = ~clk;

   swervolf_axi_mem #(.ID_WIDTH(IDW), .DATA_WIDTH(DW), .MEM_SIZE(MS), .INIT_FILE("")) dut (
      .clk(clk), .rst_n(rst_n),
      .i_awid(i_awid), .i_awaddr(i_awaddr), .i_awlen(i_awlen), .i_awsize(i_awsize),
      .i_awburst(i_awburst), .i_awvalid(i_awvalid), .o_awready(o_awready),
      .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wlast(i_wlast), .i_wvalid(i_wvalid),
      .o_wready(o_wready), .o_bid(o_bid), .o_bresp(o_bresp), .o_bvalid(o_bvalid),
      .i_bready(i_bready),
      .i_arid(i_arid), .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arsize(i_arsize),
      .i_arburst(i_arburst), .i_arvalid(i_arvalid), .o_arready(o_arready),
      .o_rid(o_rid), .o_rdata(o_rdata), .o_rresp(o_rresp), .o_rlast(o_rlast),
      .o_rvalid(o_rvalid), .i_rready(i_rready));

   int            n_cmp = 0;
   int            n_err = 0;
   logic [63:0]   model [DEPTH];
   logic [63:0]   wd [256];
   logic [7:0]    ws [256];
   logic [63:0]   rdq [256];

   typedef struct {
      logic [31:0] addr;
      int          len;
      int          size;
      int          burst;
      int          i0, i1, i2, i3;
   } rvec_t;
   rvec_t tbl [8];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic timeout(input string nm);
      n_cmp++;
      n_err++;
      $display("FAIL %s: handshake never offered, expected within 200 cycles", nm);
   endtask

   function automatic logic [63:0] pattern(input int i);
      return 64'hC0DE_0000_0000_0000 | 64'(i);
   endfunction

   // Byte address of beat k, computed directly from the burst rules.
   function automatic logic [31:0] beat_addr(input logic [31:0] a, input int len, input int size,
                                             input int burst, input int k);
      logic [31:0] step, blk, base;
      step = 32'd1 << size;
      if (burst == 0) return a;
      if (burst == 2 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
         blk  = 32'(len + 1) * step;
         base = a - (a % blk);
         return base + ((a - base + 32'(k) * step) % blk);
      end
      return a + 32'(k) * step;
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'((a % 32'(MS)) / 32'd8);
   endfunction

   task automatic model_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
`ifndef SWERVOLF_AXI_MEM_WP_EN
      for (int b = 0; b < 8; b++)
         if (s[b]) model[widx(a)][8*b +: 8] = d[8*b +: 8];
`endif
   endtask

   task automatic do_write(input logic [31:0] addr, input int len, input int size, input int burst,
                           input logic [IDW-1:0] id, input bit gaps, input int bstall);
      int n;
      i_awvalid = 1'b1; i_awaddr = addr; i_awlen = 8'(len); i_awsize = 3'(size);
      i_awburst = 2'(burst); i_awid = id;
      n = 0;
      while (!o_awready && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) timeout("aw_ready");
      @(negedge clk);
      i_awvalid = 1'b0;
      for (int k = 0; k <= len; k++) begin
         if (gaps && $urandom_range(2) == 0) begin i_wvalid = 1'b0; @(negedge clk); end
         i_wvalid = 1'b1; i_wdata = wd[k]; i_wstrb = ws[k]; i_wlast = (k == len);
         n = 0;
         while (!o_wready && n < 200) begin @(negedge clk); n++; end
         if (n >= 200) timeout("w_ready");
         model_write(beat_addr(addr, len, size, burst, k), wd[k], ws[k]);
         @(negedge clk);
      end
      i_wvalid = 1'b0; i_wlast = 1'b0;
      chk("bvalid_after_wlast", 64'(o_bvalid), 64'd1);
      chk("bid", 64'(o_bid), 64'(id));
      chk("bresp", 64'(o_bresp), 64'(EXP_BRESP));
      for (int j = 0; j < bstall; j++) begin
         @(negedge clk);
         chk("bvalid_hold", 64'(o_bvalid), 64'd1);
         chk("bid_hold", 64'(o_bid), 64'(id));
      end
      i_bready = 1'b1;
      @(negedge clk);
      i_bready = 1'b0;
      chk("bvalid_after_b", 64'(o_bvalid), 64'd0);
      chk("awready_after_b", 64'(o_awready), 64'd1);
   endtask

   // stall_beat/stall_len force one long rready gap; rnd adds random single-cycle gaps.
   task automatic do_read(input logic [31:0] addr, input int len, input int size, input int burst,
                          input logic [IDW-1:0] id, input int stall_beat, input int stall_len,
                          input bit rnd);
      int n, s;
      logic [63:0] exp;
      i_arvalid = 1'b1; i_araddr = addr; i_arlen = 8'(len); i_arsize = 3'(size);
      i_arburst = 2'(burst); i_arid = id;
      n = 0;
      while (!o_arready && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) timeout("ar_ready");
      @(negedge clk);
      i_arvalid = 1'b0;
      chk("rvalid_after_ar", 64'(o_rvalid), 64'd1);
      for (int k = 0; k <= len; k++) begin
         exp = model[widx(beat_addr(addr, len, size, burst, k))];
         s = (k == stall_beat) ? stall_len : ((rnd && $urandom_range(3) == 0) ? 1 : 0);
         for (int j = 0; j < s; j++) begin
            i_rready = 1'b0;
            @(negedge clk);
`ifndef SWERVOLF_AXI_MEM_WP_EN
            chk("rdata_hold", o_rdata, exp);
`endif
            chk("rlast_hold", 64'(o_rlast), 64'(k == len));
            chk("rid_hold", 64'(o_rid), 64'(id));
         end
         chk("rvalid", 64'(o_rvalid), 64'd1);
`ifndef SWERVOLF_AXI_MEM_WP_EN
         chk("rdata", o_rdata, exp);
`endif
         chk("rlast", 64'(o_rlast), 64'(k == len));
         chk("rid", 64'(o_rid), 64'(id));
         chk("rresp", 64'(o_rresp), 64'd0);
         rdq[k] = o_rdata;
         i_rready = 1'b1;
         @(negedge clk);
      end
      i_rready = 1'b0;
      chk("rvalid_after_last", 64'(o_rvalid), 64'd0);
      chk("arready_after_last", 64'(o_arready), 64'd1);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_awready"}, 64'(o_awready), 64'd1);
      chk({tag, "_arready"}, 64'(o_arready), 64'd1);
      chk({tag, "_wready"}, 64'(o_wready), 64'd0);
      chk({tag, "_bvalid"}, 64'(o_bvalid), 64'd0);
      chk({tag, "_rvalid"}, 64'(o_rvalid), 64'd0);
      chk({tag, "_rlast"}, 64'(o_rlast), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] old;
      int len, size, burst;
      logic [31:0] addr;

      tbl[0] = '{32'h18,   3, 3, 2, 3, 0, 1, 2};
      tbl[1] = '{32'h1100, 0, 3, 1, 32, 0, 0, 0};
      tbl[2] = '{32'h40,   3, 3, 0, 8, 8, 8, 8};
      tbl[3] = '{32'h38,   3, 3, 3, 7, 8, 9, 10};
      tbl[4] = '{32'h30,   2, 3, 2, 6, 7, 8, 0};
      tbl[5] = '{32'h0C,   3, 2, 2, 1, 0, 0, 1};
      tbl[6] = '{32'hFF8,  1, 3, 1, 511, 0, 0, 0};
      tbl[7] = '{32'h104,  3, 2, 1, 32, 33, 33, 34};
      for (int i = 0; i < DEPTH; i++) model[i] = 'x;

      // reset
      repeat (5) @(negedge clk);
      chk_reset_outputs("reset");
      chk("reset_bid", 64'(o_bid), 64'd0);
      chk("reset_rid", 64'(o_rid), 64'd0);
      chk("reset_rdata", o_rdata, 64'd0);
      chk("reset_bresp", 64'(o_bresp), 64'd0);
      chk("reset_rresp", 64'(o_rresp), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

`ifdef SWERVOLF_AXI_MEM_WP_EN
      do_read(32'h0, 0, 3, 1, 6'h1, -1, 0, 1'b0);
      old = rdq[0];
      wd[0] = 64'hDEAD; ws[0] = 8'hFF;
      do_write(32'h0, 0, 3, 1, 6'h2, 1'b0, 0);
      do_read(32'h0, 0, 3, 1, 6'h3, -1, 0, 1'b0);
      chk("wp_read_unchanged", rdq[0], old);
`else
      // W beats offered before AW must stall
      i_wvalid = 1'b1; i_wlast = 1'b1;
      repeat (2) begin @(negedge clk); chk("wready_before_aw", 64'(o_wready), 64'd0); end
      i_wvalid = 1'b0; i_wlast = 1'b0;

      // prefill the whole array with a known pattern
      for (int h = 0; h < 2; h++) begin
         for (int k = 0; k < 256; k++) begin wd[k] = pattern(h * 256 + k); ws[k] = 8'hFF; end
         do_write(32'(h * 32'h800), 255, 3, 1, 6'(h), 1'b0, 0);
      end

      // table-driven reads with hand-derived word indices
      for (int t = 0; t < 8; t++) begin
         do_read(tbl[t].addr, tbl[t].len, tbl[t].size, tbl[t].burst, 6'(t), -1, 0, 1'b0);
         chk($sformatf("tbl%0d_b0", t), rdq[0], pattern(tbl[t].i0));
         if (tbl[t].len >= 1) chk($sformatf("tbl%0d_b1", t), rdq[1], pattern(tbl[t].i1));
         if (tbl[t].len >= 2) chk($sformatf("tbl%0d_b2", t), rdq[2], pattern(tbl[t].i2));
         if (tbl[t].len >= 3) chk($sformatf("tbl%0d_b3", t), rdq[3], pattern(tbl[t].i3));
      end

      // INCR 64-bit write then read back
      for (int k = 0; k < 4; k++) begin wd[k] = 64'(k + 1); ws[k] = 8'hFF; end
      do_write(32'h100, 3, 3, 1, 6'h15, 1'b0, 2);
      do_read(32'h100, 3, 3, 1, 6'h16, -1, 0, 1'b0);
      for (int k = 0; k < 4; k++) chk($sformatf("incr_b%0d", k), rdq[k], 64'(k + 1));

      // narrow write of the upper half, then aliased read
      wd[0] = 64'hAABBCCDD_00000000; ws[0] = 8'hF0;
      do_write(32'h104, 0, 2, 1, 6'h21, 1'b0, 0);
      do_read(32'h100, 0, 3, 1, 6'h22, -1, 0, 1'b0);
      chk("narrow_word", rdq[0], 64'hAABBCCDD_00000001);
      do_read(32'h1100, 0, 3, 1, 6'h23, -1, 0, 1'b0);
      chk("alias_word", rdq[0], 64'hAABBCCDD_00000001);

      // rready dropped for 3 cycles mid-burst
      do_read(32'h100, 3, 3, 1, 6'h24, 1, 3, 1'b0);
      chk("bp_b0", rdq[0], 64'hAABBCCDD_00000001);
      chk("bp_b1", rdq[1], 64'd2);
      chk("bp_b2", rdq[2], 64'd3);
      chk("bp_b3", rdq[3], 64'd4);

      // same-cycle write and read of word 0x200: read sees old data
      i_awvalid = 1'b1; i_awaddr = 32'h200; i_awlen = 8'd0; i_awsize = 3'd3;
      i_awburst = 2'd1; i_awid = 6'h30;
      @(negedge clk);
      i_awvalid = 1'b0;
      chk("coll_wready", 64'(o_wready), 64'd1);
      chk("coll_arready", 64'(o_arready), 64'd1);
      i_wvalid = 1'b1; i_wdata = 64'h1234_5678_9ABC_DEF0; i_wstrb = 8'hFF; i_wlast = 1'b1;
      i_arvalid = 1'b1; i_araddr = 32'h200; i_arlen = 8'd0; i_arsize = 3'd3;
      i_arburst = 2'd1; i_arid = 6'h31;
      @(negedge clk);
      i_wvalid = 1'b0; i_wlast = 1'b0; i_arvalid = 1'b0;
      chk("coll_old_data", o_rdata, pattern(64));
      chk("coll_bvalid", 64'(o_bvalid), 64'd1);
      i_rready = 1'b1; i_bready = 1'b1;
      @(negedge clk);
      i_rready = 1'b0; i_bready = 1'b0;
      model_write(32'h200, 64'h1234_5678_9ABC_DEF0, 8'hFF);
      do_read(32'h200, 0, 3, 1, 6'h32, -1, 0, 1'b0);
      chk("coll_new_data", rdq[0], 64'h1234_5678_9ABC_DEF0);

      // reset mid-burst on both channels; written beat survives
      i_awvalid = 1'b1; i_awaddr = 32'h300; i_awlen = 8'd3; i_awsize = 3'd3;
      i_awburst = 2'd1; i_awid = 6'h33;
      @(negedge clk);
      i_awvalid = 1'b0;
      i_wvalid = 1'b1; i_wdata = 64'h5555_AAAA_5555_AAAA; i_wstrb = 8'hFF; i_wlast = 1'b0;
      i_arvalid = 1'b1; i_araddr = 32'h0; i_arlen = 8'd7; i_arsize = 3'd3; i_arburst = 2'd1;
      @(negedge clk);
      i_wvalid = 1'b0; i_arvalid = 1'b0;
      model_write(32'h300, 64'h5555_AAAA_5555_AAAA, 8'hFF);
      chk("midburst_rvalid", 64'(o_rvalid), 64'd1);
      chk("midburst_wready", 64'(o_wready), 64'd1);
      #2 rst_n = 1'b0;
      #1 chk_reset_outputs("abort");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      do_read(32'h300, 1, 3, 1, 6'h34, -1, 0, 1'b0);
      chk("abort_kept", rdq[0], 64'h5555_AAAA_5555_AAAA);

      // randomized bursts against the model
      for (int it = 0; it < 40; it++) begin
         size  = $urandom_range(0, 3);
         addr  = 32'($urandom_range(0, 32'h1FFF)) & ~((32'd1 << size) - 32'd1);
         len   = $urandom_range(0, 15);
         burst = $urandom_range(0, 3);
         if ($urandom_range(1) == 1) begin
            for (int k = 0; k <= len; k++) begin
               wd[k] = {$urandom, $urandom};
               ws[k] = 8'($urandom);
            end
            do_write(addr, len, size, burst, 6'($urandom), 1'b1, $urandom_range(0, 2));
         end else begin
            do_read(addr, len, size, burst, 6'($urandom), -1, 0, 1'b1);
         end
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
